// File: rtl/bip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bip_pkg
// Description : Shared definitions for the BIP control unit: default widths,
//               opcode encodings, selA encodings and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package bip_pkg;

    // Default widths
    localparam int c_NB_PC            = 11;
    localparam int c_NB_OPCODE        = 5;
    localparam int c_NB_OPERANDO      = 11;
    localparam int c_NB_INSTR         = 16;
    localparam int c_NB_DECODER_SEL_A = 2;
    localparam int c_NB_CYCLES        = 32;

    // Opcodes; everything from 01000 upward executes as a NOP
    localparam logic [c_NB_OPCODE-1:0] c_OP_HLT  = 5'b00000;
    localparam logic [c_NB_OPCODE-1:0] c_OP_STO  = 5'b00001;
    localparam logic [c_NB_OPCODE-1:0] c_OP_LD   = 5'b00010;
    localparam logic [c_NB_OPCODE-1:0] c_OP_LDI  = 5'b00011;
    localparam logic [c_NB_OPCODE-1:0] c_OP_ADD  = 5'b00100;
    localparam logic [c_NB_OPCODE-1:0] c_OP_ADDI = 5'b00101;
    localparam logic [c_NB_OPCODE-1:0] c_OP_SUB  = 5'b00110;
    localparam logic [c_NB_OPCODE-1:0] c_OP_SUBI = 5'b00111;

    // Accumulator input source select
    localparam logic [c_NB_DECODER_SEL_A-1:0] c_SEL_A_MEM     = 2'b00;
    localparam logic [c_NB_DECODER_SEL_A-1:0] c_SEL_A_OPERAND = 2'b01;
    localparam logic [c_NB_DECODER_SEL_A-1:0] c_SEL_A_ALU     = 2'b10;

    // FSM state encoding
    localparam int                   c_NB_STATE  = 3;
    localparam logic [c_NB_STATE-1:0] c_ST_IDLE   = 3'd0;
    localparam logic [c_NB_STATE-1:0] c_ST_FETCH  = 3'd1;
    localparam logic [c_NB_STATE-1:0] c_ST_DECODE = 3'd2;
    localparam logic [c_NB_STATE-1:0] c_ST_EXEC   = 3'd3;
    localparam logic [c_NB_STATE-1:0] c_ST_HALT   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/bip_instr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : bip_instr_decoder
// Description : Purely combinational opcode decoder producing the datapath
//               and data-memory control set for one BIP opcode.
// Revision    : 1.0 - initial release
// ============================================================================
module bip_instr_decoder
    import bip_pkg::*;
(
    input  logic [c_NB_OPCODE-1:0]        i_opcode,
    output logic [c_NB_DECODER_SEL_A-1:0] o_sel_a,
    output logic                          o_sel_b,
    output logic                          o_wr_acc,
    output logic                          o_dm_rd,
    output logic                          o_dm_wr,
    output logic                          o_is_hlt
);

    // Opcode lookup; unlisted opcodes fall through to the all-zero NOP set
    always_comb begin
        o_sel_a  = c_SEL_A_MEM;
        o_sel_b  = 1'b0;
        o_wr_acc = 1'b0;
        o_dm_rd  = 1'b0;
        o_dm_wr  = 1'b0;
        o_is_hlt = 1'b0;
        case (i_opcode)
            c_OP_HLT:  o_is_hlt = 1'b1;
            c_OP_STO:  o_dm_wr  = 1'b1;
            c_OP_LD: begin
                o_sel_a  = c_SEL_A_MEM;
                o_wr_acc = 1'b1;
                o_dm_rd  = 1'b1;
            end
            c_OP_LDI: begin
                o_sel_a  = c_SEL_A_OPERAND;
                o_wr_acc = 1'b1;
            end
            c_OP_ADD, c_OP_SUB: begin
                o_sel_a  = c_SEL_A_ALU;
                o_sel_b  = 1'b0;
                o_wr_acc = 1'b1;
                o_dm_rd  = 1'b1;
            end
            c_OP_ADDI, c_OP_SUBI: begin
                o_sel_a  = c_SEL_A_ALU;
                o_sel_b  = 1'b1;
                o_wr_acc = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bip_control.sv
`default_nettype none
// ============================================================================
// Module      : bip_control
// Description : BIP processor control unit. Runs a fixed FETCH -> DECODE ->
//               EXEC sequence per instruction, drives datapath and memory
//               strobes, and parks in HALT on an HLT opcode.
//               Optional cycle counter enabled by macro BIP_CYCLE_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bip_control
    import bip_pkg::*;
#(
    parameter int NB_PC            = c_NB_PC,
    parameter int NB_OPCODE        = c_NB_OPCODE,
    parameter int NB_OPERANDO      = c_NB_OPERANDO,
    parameter int NB_INSTR         = c_NB_INSTR,
    parameter int NB_DECODER_SEL_A = c_NB_DECODER_SEL_A,
    parameter int NB_CYCLES        = c_NB_CYCLES
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    output logic [NB_PC-1:0]            o_pm_addr,
    output logic                        o_pm_rd,
    input  logic [NB_INSTR-1:0]         i_pm_data,
    output logic [NB_OPERANDO-1:0]      o_dm_addr,
    output logic                        o_dm_rd,
    output logic                        o_dm_wr,
    output logic [NB_DECODER_SEL_A-1:0] o_selA,
    output logic                        o_selB,
    output logic                        o_wrAcc,
    output logic [NB_OPCODE-1:0]        o_op,
    output logic [NB_OPERANDO-1:0]      o_operando,
    output logic                        o_halted,
    output logic [NB_CYCLES-1:0]        o_cycles
);

    logic [c_NB_STATE-1:0]       r_state;
    logic [NB_PC-1:0]            r_pc;
    logic [NB_INSTR-1:0]         r_ir;

    logic [NB_OPCODE-1:0]        w_dec_opcode;
    logic [NB_DECODER_SEL_A-1:0] w_dec_sel_a;
    logic                        w_dec_sel_b;
    logic                        w_dec_wr_acc;
    logic                        w_dec_dm_rd;
    logic                        w_dec_dm_wr;
    logic                        w_dec_is_hlt;

    // One decoder serves both stages: in DECODE it looks ahead at the word
    // arriving from program memory (dm_rd lookahead and HLT detection), in
    // every other state it decodes the latched instruction register.
    assign w_dec_opcode = (r_state == c_ST_DECODE) ? i_pm_data[NB_INSTR-1 -: NB_OPCODE]
                                                   : r_ir[NB_INSTR-1 -: NB_OPCODE];

    bip_instr_decoder u_decoder (
        .i_opcode (w_dec_opcode),
        .o_sel_a  (w_dec_sel_a),
        .o_sel_b  (w_dec_sel_b),
        .o_wr_acc (w_dec_wr_acc),
        .o_dm_rd  (w_dec_dm_rd),
        .o_dm_wr  (w_dec_dm_wr),
        .o_is_hlt (w_dec_is_hlt)
    );

    // Sequencer: state, program counter and instruction register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= c_ST_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (i_start) r_state <= c_ST_FETCH;
                end
                c_ST_FETCH: r_state <= c_ST_DECODE;
                c_ST_DECODE: begin
                    r_ir    <= i_pm_data;
                    r_state <= w_dec_is_hlt ? c_ST_HALT : c_ST_EXEC;
                end
                c_ST_EXEC: begin
                    // Natural wrap from all-ones back to zero
                    r_pc    <= r_pc + NB_PC'(1);
                    r_state <= c_ST_FETCH;
                end
                c_ST_HALT: r_state <= c_ST_HALT;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign o_pm_addr = r_pc;

    // Output decode from the registered state; reset therefore forces every
    // strobe low immediately without waiting for a clock edge.
    always_comb begin
        o_pm_rd    = 1'b0;
        o_dm_addr  = '0;
        o_dm_rd    = 1'b0;
        o_dm_wr    = 1'b0;
        o_selA     = '0;
        o_selB     = 1'b0;
        o_wrAcc    = 1'b0;
        o_op       = '0;
        o_operando = '0;
        o_halted   = 1'b0;
        case (r_state)
            c_ST_FETCH: o_pm_rd = 1'b1;
            c_ST_DECODE: begin
                // Issue the data read now so it returns during EXEC
                if (w_dec_dm_rd) begin
                    o_dm_rd   = 1'b1;
                    o_dm_addr = i_pm_data[NB_OPERANDO-1:0];
                end
            end
            c_ST_EXEC: begin
                o_op       = r_ir[NB_INSTR-1 -: NB_OPCODE];
                o_operando = r_ir[NB_OPERANDO-1:0];
                o_dm_addr  = r_ir[NB_OPERANDO-1:0];
                o_selA     = w_dec_sel_a;
                o_selB     = w_dec_sel_b;
                o_wrAcc    = w_dec_wr_acc;
                o_dm_wr    = w_dec_dm_wr;
            end
            c_ST_HALT: o_halted = 1'b1;
            default: ;
        endcase
    end

`ifdef BIP_CYCLE_COUNT_EN
    logic [NB_CYCLES-1:0] r_cycles;
    logic                 w_busy;

    assign w_busy = (r_state == c_ST_FETCH) || (r_state == c_ST_DECODE) ||
                    (r_state == c_ST_EXEC);

    // Saturating count of clocks spent executing instructions
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cycles <= '0;
        end else if (w_busy && (r_cycles != {NB_CYCLES{1'b1}})) begin
            r_cycles <= r_cycles + NB_CYCLES'(1);
        end
    end

    assign o_cycles = r_cycles;
`else
    assign o_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bip_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_bip_control
// Description : Self-checking bench for bip_control. Expected output events
//               are queued with the stimulus; a negedge monitor pops and
//               compares them whenever the DUT raises a strobe or halts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bip_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] pm_addr;
    logic        pm_rd;
    logic [15:0] pm_data = '0;
    logic [10:0] dm_addr;
    logic        dm_rd;
    logic        dm_wr;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        wr_acc;
    logic [4:0]  op;
    logic [10:0] operando;
    logic        halted;
    logic [31:0] cycles;

    always #5 clk = ~clk;

    bip_control dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .o_pm_addr  (pm_addr),
        .o_pm_rd    (pm_rd),
        .i_pm_data  (pm_data),
        .o_dm_addr  (dm_addr),
        .o_dm_rd    (dm_rd),
        .o_dm_wr    (dm_wr),
        .o_selA     (sel_a),
        .o_selB     (sel_b),
        .o_wrAcc    (wr_acc),
        .o_op       (op),
        .o_operando (operando),
        .o_halted   (halted),
        .o_cycles   (cycles)
    );

    // Synchronous program memory, one-cycle read latency
    logic [15:0] prog [0:2047];
    always @(posedge clk) if (pm_rd) pm_data <= prog[pm_addr];

    typedef struct packed {
        logic [15:0] cyc;
        logic [10:0] pm_addr;
        logic        pm_rd;
        logic [10:0] dm_addr;
        logic        dm_rd;
        logic        dm_wr;
        logic [1:0]  sel_a;
        logic        sel_b;
        logic        wr_acc;
        logic [4:0]  op;
        logic [10:0] operando;
        logic        halted;
    } ev_t;

    ev_t exp_q [$];
    int  n_checks = 0;
    int  n_err    = 0;
    int  edge_cnt = 0;
    int  start_edge = 0;
    int  ev_n = 0;

    always @(posedge clk) edge_cnt++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    function automatic ev_t snap_now(input int c);
        ev_t s;
        s.cyc = 16'(c); s.pm_addr = pm_addr; s.pm_rd = pm_rd; s.dm_addr = dm_addr;
        s.dm_rd = dm_rd; s.dm_wr = dm_wr; s.sel_a = sel_a; s.sel_b = sel_b;
        s.wr_acc = wr_acc; s.op = op; s.operando = operando; s.halted = halted;
        return s;
    endfunction

    function automatic ev_t ev_f(input int c, input int pc);
        ev_t e = '0;
        e.cyc = 16'(c); e.pm_addr = 11'(pc); e.pm_rd = 1'b1;
        return e;
    endfunction

    function automatic ev_t ev_d(input int c, input int pc, input logic [10:0] a);
        ev_t e = '0;
        e.cyc = 16'(c); e.pm_addr = 11'(pc); e.dm_rd = 1'b1; e.dm_addr = a;
        return e;
    endfunction

    function automatic ev_t ev_x(input int c, input int pc, input logic [4:0] o,
                                 input logic [10:0] n, input logic [1:0] sa,
                                 input logic sb, input logic wa, input logic dw);
        ev_t e = '0;
        e.cyc = 16'(c); e.pm_addr = 11'(pc); e.op = o; e.operando = n; e.dm_addr = n;
        e.sel_a = sa; e.sel_b = sb; e.wr_acc = wa; e.dm_wr = dw;
        return e;
    endfunction

    function automatic ev_t ev_h(input int c, input int pc);
        ev_t e = '0;
        e.cyc = 16'(c); e.pm_addr = 11'(pc); e.halted = 1'b1;
        return e;
    endfunction

    function automatic logic [15:0] ins(input logic [4:0] o, input logic [10:0] n);
        return {o, n};
    endfunction

    function automatic logic [31:0] exp_cyc(input int n);
`ifdef BIP_CYCLE_COUNT_EN
        return 32'(n);
`else
        return (n == -1) ? 32'd1 : 32'd0;
`endif
    endfunction

    // Monitor: an event is any strobe/select activity or the entry into HALT
    ev_t  mon_act;
    ev_t  mon_exp;
    logic mon_evt;
    logic prev_halted = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_halted = 1'b0;
        end else begin
            mon_act = snap_now(edge_cnt - start_edge + 1);
            mon_evt = pm_rd | dm_rd | dm_wr | wr_acc | sel_b | (sel_a != 2'b00) |
                      (halted & ~prev_halted);
            prev_halted = halted;
            if (mon_evt) begin
                ev_n++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_event: got %h required none", mon_act);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk($sformatf("event%0d", ev_n), 64'(mon_act), 64'(mon_exp));
                end
            end
        end
    end

    task automatic fill_nop();
        for (int i = 0; i < 2048; i++) prog[i] = ins(5'b01000, 11'h000);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start      = 1'b1;
        start_edge = edge_cnt + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halt(input int bound);
        int n = 0;
        while (!halted && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("halt_reached", 64'(halted), 64'd1);
        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        fill_nop();
        @(negedge clk);
        chk("reset_outs", 64'(snap_now(0)), 64'd0);
        chk("reset_cycles", 64'(cycles), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of an ADDI execute cycle
        prog[0] = ins(5'b00101, 11'd9);
        exp_q.push_back(ev_f(1, 0));
        exp_q.push_back(ev_x(3, 0, 5'b00101, 11'd9, 2'b10, 1'b1, 1'b1, 1'b0));
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_outs", 64'(snap_now(0)), 64'd0);
        chk("async_reset_cycles", 64'(cycles), 64'd0);
        chk("async_reset_queue", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_after_reset", 64'(snap_now(0)), 64'd0);

        // LDI 5; ADDI 3; STO 10; HLT
        fill_nop();
        prog[0] = ins(5'b00011, 11'd5);
        prog[1] = ins(5'b00101, 11'd3);
        prog[2] = ins(5'b00001, 11'd10);
        prog[3] = ins(5'b00000, 11'd0);
        do_reset();
        exp_q.push_back(ev_f(1, 0));
        exp_q.push_back(ev_x(3, 0, 5'b00011, 11'd5, 2'b01, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(ev_f(4, 1));
        exp_q.push_back(ev_x(6, 1, 5'b00101, 11'd3, 2'b10, 1'b1, 1'b1, 1'b0));
        exp_q.push_back(ev_f(7, 2));
        exp_q.push_back(ev_x(9, 2, 5'b00001, 11'd10, 2'b00, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(ev_f(10, 3));
        exp_q.push_back(ev_h(12, 3));
        pulse_start();
        wait_halt(40);
        chk("progA_cycles", 64'(cycles), 64'(exp_cyc(11)));

        // LD 7; SUBI 7FF; ADD 12; SUB 400; NOP(01010); STO 1; HLT
        fill_nop();
        prog[0] = ins(5'b00010, 11'd7);
        prog[1] = ins(5'b00111, 11'h7FF);
        prog[2] = ins(5'b00100, 11'd12);
        prog[3] = ins(5'b00110, 11'h400);
        prog[4] = ins(5'b01010, 11'h155);
        prog[5] = ins(5'b00001, 11'd1);
        prog[6] = ins(5'b00000, 11'd0);
        do_reset();
        exp_q.push_back(ev_f(1, 0));
        exp_q.push_back(ev_d(2, 0, 11'd7));
        exp_q.push_back(ev_x(3, 0, 5'b00010, 11'd7, 2'b00, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(ev_f(4, 1));
        exp_q.push_back(ev_x(6, 1, 5'b00111, 11'h7FF, 2'b10, 1'b1, 1'b1, 1'b0));
        exp_q.push_back(ev_f(7, 2));
        exp_q.push_back(ev_d(8, 2, 11'd12));
        exp_q.push_back(ev_x(9, 2, 5'b00100, 11'd12, 2'b10, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(ev_f(10, 3));
        exp_q.push_back(ev_d(11, 3, 11'h400));
        exp_q.push_back(ev_x(12, 3, 5'b00110, 11'h400, 2'b10, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(ev_f(13, 4));
        exp_q.push_back(ev_f(16, 5));
        exp_q.push_back(ev_x(18, 5, 5'b00001, 11'd1, 2'b00, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(ev_f(19, 6));
        exp_q.push_back(ev_h(21, 6));
        pulse_start();
        wait_halt(60);
        chk("progB_cycles", 64'(cycles), 64'(exp_cyc(20)));
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        chk("halt_ignores_start", 64'({halted, pm_addr}), 64'({1'b1, 11'd6}));

        // Two instructions plus HLT: eight busy cycles
        fill_nop();
        prog[0] = ins(5'b00011, 11'd1);
        prog[1] = ins(5'b00011, 11'd2);
        prog[2] = ins(5'b00000, 11'd0);
        do_reset();
        exp_q.push_back(ev_f(1, 0));
        exp_q.push_back(ev_x(3, 0, 5'b00011, 11'd1, 2'b01, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(ev_f(4, 1));
        exp_q.push_back(ev_x(6, 1, 5'b00011, 11'd2, 2'b01, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(ev_f(7, 2));
        exp_q.push_back(ev_h(9, 2));
        pulse_start();
        wait_halt(40);
        chk("progC_cycles", 64'(cycles), 64'(exp_cyc(8)));
        repeat (5) @(negedge clk);
        chk("progC_cycles_held", 64'(cycles), 64'(exp_cyc(8)));

        // All-NOP sweep: pc wraps 2047 -> 0, where an HLT is placed once
        // the first pass has moved on.
        fill_nop();
        do_reset();
        for (int k = 0; k <= 2048; k++) exp_q.push_back(ev_f(3 * k + 1, k % 2048));
        exp_q.push_back(ev_h(3 * 2048 + 3, 0));
        pulse_start();
        begin
            int n = 0;
            while (pm_addr != 11'd5 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("wrap_reached_pc5", 64'(pm_addr), 64'd5);
        end
        prog[0] = ins(5'b00000, 11'd0);
        wait_halt(7000);
        chk("wrap_halt_pc", 64'(pm_addr), 64'd0);
        chk("wrap_cycles", 64'(cycles), 64'(exp_cyc(6146)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
